// File: rtl/blackjack_table_fsm.sv
// -----------------------------------------------------------------------------
// blackjack_table_fsm
//   Table controller for NUM_PLAYERS seats plus a dealer (seat NUM_PLAYERS+1).
//   It runs seat-count select, a round-robin initial deal, per-seat turns
//   (human or AI), dealer play and per-seat settlement. It sits between the
//   button/AI inputs and the card-draw / hand-scoring datapath.
//
//   Optional feature macro: BLACKJACK_HIT_SOFT17_EN
//     defined   -> the dealer also draws on a soft 17 (high==17, low!=high)
//     undefined -> the dealer stands on any total >= DEALER_STAND
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   hold, hit         human buttons (hold also cycles the human count in SELECT,
//                     hit also starts a round), one-cycle pulses
//   ai_hold, ai_hit   AI decision for the current AI seat
//   cards_updated     one-cycle pulse: draw datapath finished
//   hand_high/low     5-bit ace-high / ace-low totals, player i at slice i-1,
//                     dealer at slice NUM_PLAYERS
//   user_select       seat being drawn for (0 = none), registered
//   active_seat       seat whose turn it is (0 = none)
//   num_humans        seats 1..num_humans are human, the rest AI
//   current_state     encoded state
//   win_mask/push_mask per-player result, captured on RESULT entry
//   game_over         high in RESULT
// -----------------------------------------------------------------------------

// Best-total reduction for one hand: ace-high total if it does not bust,
// otherwise the ace-low total if it is a legal 1..21, otherwise the bust
// sentinel 5'h1F.
module bj_hand_best (
    input  logic [4:0] hi,
    input  logic [4:0] lo,
    output logic [4:0] best
);
    always_comb begin
        if (hi <= 5'd21)
            best = hi;
        else if ((lo >= 5'd1) && (lo <= 5'd21))
            best = lo;
        else
            best = 5'h1F;
    end
endmodule

module blackjack_table_fsm #(
    parameter int NUM_PLAYERS  = 2,
    parameter int INIT_CARDS   = 2,
    parameter int DEALER_STAND = 17,
    parameter int SEL_W        = $clog2(NUM_PLAYERS + 2)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           hold,
    input  logic                           hit,
    input  logic                           ai_hold,
    input  logic                           ai_hit,
    input  logic                           cards_updated,
    input  logic [5*(NUM_PLAYERS+1)-1:0]   hand_high,
    input  logic [5*(NUM_PLAYERS+1)-1:0]   hand_low,
    output logic [SEL_W-1:0]               user_select,
    output logic [SEL_W-1:0]               active_seat,
    output logic [SEL_W-1:0]               num_humans,
    output logic [3:0]                     current_state,
    output logic [NUM_PLAYERS-1:0]         win_mask,
    output logic [NUM_PLAYERS-1:0]         push_mask,
    output logic                           game_over
);

    localparam int RND_W = $clog2(INIT_CARDS + 1);
    localparam logic [SEL_W-1:0] LAST_P = SEL_W'(NUM_PLAYERS);
    localparam logic [SEL_W-1:0] DEALER = SEL_W'(NUM_PLAYERS + 1);
    localparam logic [SEL_W-1:0] SEAT1  = SEL_W'(1);

    typedef enum logic [3:0] {
        S_SELECT      = 4'd0,
        S_DEAL        = 4'd1,
        S_DRAW        = 4'd2,
        S_TURN        = 4'd3,
        S_DEALER_TURN = 4'd4,
        S_RESULT      = 4'd5
    } state_t;

    state_t                 state_q, state_d;
    logic [SEL_W-1:0]       num_humans_q, num_humans_d;
    logic [SEL_W-1:0]       user_select_q, user_select_d;
    logic [SEL_W-1:0]       active_seat_q, active_seat_d;
    logic [SEL_W-1:0]       deal_seat_q, deal_seat_d;
    logic [RND_W-1:0]       deal_round_q, deal_round_d;
    logic [NUM_PLAYERS-1:0] win_q, win_d, push_q, push_d;
    logic                   game_over_q, game_over_d;

    // ---------------------------------------------------------------- scoring
    logic [NUM_PLAYERS:0][4:0] best_all;
    logic [NUM_PLAYERS-1:0]    p_bust, win_c, push_c;
    logic [4:0]                dlr_best, cur_best;
    logic                      dlr_bust, all_bust;

    // One scorer per seat; instance k takes slice k of the packed hand buses.
    bj_hand_best u_best [NUM_PLAYERS:0] (
        .hi   (hand_high),
        .lo   (hand_low),
        .best (best_all)
    );

    assign dlr_best = best_all[NUM_PLAYERS];
    assign dlr_bust = (dlr_best == 5'h1F);

    for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_cmp
        assign p_bust[i] = (best_all[i] == 5'h1F);
        assign win_c[i]  = !p_bust[i] && (dlr_bust || (best_all[i] > dlr_best));
        assign push_c[i] = !p_bust[i] && !dlr_bust && (best_all[i] == dlr_best);
    end

    assign all_bust = &p_bust;

    // Total of the seat currently taking its turn.
    always_comb begin
        cur_best = 5'd0;
        for (int i = 0; i < NUM_PLAYERS; i++)
            if (active_seat_q == SEL_W'(i + 1))
                cur_best = best_all[i];
    end

    // ------------------------------------------------------------- decisions
    logic is_human, dec_hold, dec_hit, turn_adv, last_seat;
    logic in_deal, draw_is_dlr, dlr_draw;

    assign is_human    = (active_seat_q <= num_humans_q);
    assign dec_hold    = is_human ? hold : ai_hold;
    assign dec_hit     = is_human ? hit  : ai_hit;
    // A seat at 21 or bust (sentinel > 21) has nothing left to decide.
    assign turn_adv    = (cur_best >= 5'd21) || dec_hold;
    assign last_seat   = (active_seat_q >= LAST_P);
    // Counters only move on DRAW exit, so deal_round tells us whether this
    // draw belongs to the initial deal.
    assign in_deal     = (deal_round_q < RND_W'(INIT_CARDS));
    assign draw_is_dlr = (user_select_q == DEALER);

`ifdef BLACKJACK_HIT_SOFT17_EN
    logic [4:0] dlr_hi, dlr_lo;
    logic       soft17;
    assign dlr_hi   = hand_high[5*NUM_PLAYERS +: 5];
    assign dlr_lo   = hand_low[5*NUM_PLAYERS +: 5];
    assign soft17   = (dlr_best == 5'd17) && (dlr_hi == 5'd17) && (dlr_lo != dlr_hi);
    assign dlr_draw = !all_bust && ((dlr_best < 5'(DEALER_STAND)) || soft17);
`else
    assign dlr_draw = !all_bust && (dlr_best < 5'(DEALER_STAND));
`endif

    // --------------------------------------------------------- state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_SELECT;
            num_humans_q  <= SEAT1;
            user_select_q <= '0;
            active_seat_q <= '0;
            deal_seat_q   <= '0;
            deal_round_q  <= '0;
            win_q         <= '0;
            push_q        <= '0;
            game_over_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            num_humans_q  <= num_humans_d;
            user_select_q <= user_select_d;
            active_seat_q <= active_seat_d;
            deal_seat_q   <= deal_seat_d;
            deal_round_q  <= deal_round_d;
            win_q         <= win_d;
            push_q        <= push_d;
            game_over_q   <= game_over_d;
        end
    end

    // ------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_SELECT:      if (!hold && hit) state_d = S_DEAL;
            S_DEAL:        state_d = in_deal ? S_DRAW : S_TURN;
            S_DRAW:
                if (cards_updated)
                    state_d = in_deal     ? S_DEAL :
                              draw_is_dlr ? S_DEALER_TURN : S_TURN;
            S_TURN:
                if (turn_adv)
                    state_d = last_seat ? S_DEALER_TURN : S_TURN;
                else if (dec_hit)
                    state_d = S_DRAW;
            S_DEALER_TURN: state_d = dlr_draw ? S_DRAW : S_RESULT;
            S_RESULT:      if (hold || hit) state_d = S_SELECT;
            default:       state_d = S_SELECT;
        endcase
    end

    // ------------------------------------------------------ registered outputs
    always_comb begin
        num_humans_d  = num_humans_q;
        user_select_d = user_select_q;
        active_seat_d = active_seat_q;
        deal_seat_d   = deal_seat_q;
        deal_round_d  = deal_round_q;
        win_d         = win_q;
        push_d        = push_q;
        game_over_d   = game_over_q;
        case (state_q)
            S_SELECT:
                if (hold)
                    num_humans_d = (num_humans_q == LAST_P) ? '0 : num_humans_q + 1'b1;
                else if (hit) begin
                    deal_round_d = '0;
                    deal_seat_d  = SEAT1;
                end
            S_DEAL:
                if (in_deal) user_select_d = deal_seat_q;
                else         active_seat_d = SEAT1;
            S_DRAW:
                if (cards_updated) begin
                    user_select_d = '0;
                    if (in_deal) begin
                        if (deal_seat_q == DEALER) begin
                            deal_seat_d  = SEAT1;
                            deal_round_d = deal_round_q + 1'b1;
                        end else begin
                            deal_seat_d  = deal_seat_q + 1'b1;
                        end
                    end
                end
            S_TURN:
                if (turn_adv)
                    active_seat_d = last_seat ? DEALER : active_seat_q + 1'b1;
                else if (dec_hit)
                    user_select_d = active_seat_q;
            S_DEALER_TURN:
                if (dlr_draw) begin
                    user_select_d = DEALER;
                end else begin
                    win_d         = win_c;
                    push_d        = push_c;
                    game_over_d   = 1'b1;
                    active_seat_d = '0;
                end
            S_RESULT:
                if (hold || hit) begin
                    win_d       = '0;
                    push_d      = '0;
                    game_over_d = 1'b0;
                end
            default: begin
                user_select_d = '0;
                active_seat_d = '0;
                win_d         = '0;
                push_d        = '0;
                game_over_d   = 1'b0;
            end
        endcase
    end

    assign user_select   = user_select_q;
    assign active_seat   = active_seat_q;
    assign num_humans    = num_humans_q;
    assign current_state = state_q;
    assign win_mask      = win_q;
    assign push_mask     = push_q;
    assign game_over     = game_over_q;

endmodule

// File: tb/tb_blackjack_table_fsm.sv
// -----------------------------------------------------------------------------
// tb_blackjack_table_fsm
//   Directed bench for blackjack_table_fsm with NUM_PLAYERS=2, INIT_CARDS=2,
//   DEALER_STAND=17. Seat 3 is the dealer. Inputs change 1 time unit after a
//   rising edge, outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_blackjack_table_fsm;
    localparam int NP = 2;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          rst, hold, hit, ai_hold, ai_hit, cards_updated;
    logic [14:0]   hand_high, hand_low;
    logic [SW-1:0] user_select, active_seat, num_humans;
    logic [3:0]    current_state;
    logic [NP-1:0] win_mask, push_mask;
    logic          game_over;

    int tests = 0;
    int fails = 0;
    int deal_seq [6] = '{1, 2, 3, 1, 2, 3};

    blackjack_table_fsm #(
        .NUM_PLAYERS(NP), .INIT_CARDS(2), .DEALER_STAND(17), .SEL_W(SW)
    ) dut (
        .clk(clk), .rst(rst), .hold(hold), .hit(hit),
        .ai_hold(ai_hold), .ai_hit(ai_hit), .cards_updated(cards_updated),
        .hand_high(hand_high), .hand_low(hand_low),
        .user_select(user_select), .active_seat(active_seat),
        .num_humans(num_humans), .current_state(current_state),
        .win_mask(win_mask), .push_mask(push_mask), .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_hands(input logic [4:0] p1h, p1l, p2h, p2l, dh, dl);
        hand_high = {dh, p2h, p1h};
        hand_low  = {dl, p2l, p1l};
    endtask

    // Starts in DEAL; draws 1,2,3,1,2,3 with cards_updated two cycles after
    // each DRAW entry, then expects TURN with seat 1 active.
    task automatic run_deal();
        for (int k = 0; k < 6; k++) begin
            step();
            chk("deal_draw_state", current_state, 2);
            chk("deal_user_select", user_select, deal_seq[k]);
            step();
            chk("draw_hold_select", user_select, deal_seq[k]);
            cards_updated = 1'b1; step(); cards_updated = 1'b0;
            chk("deal_back_state", current_state, 1);
            chk("deal_select_clear", user_select, 0);
        end
        step();
        chk("turn_entry_state", current_state, 3);
        chk("turn_entry_seat", active_seat, 1);
    endtask

    initial begin
        rst = 1'b1; hold = 0; hit = 0; ai_hold = 0; ai_hit = 0; cards_updated = 0;
        set_hands(15, 15, 12, 12, 10, 10);
        step(); step();
        rst = 1'b0;
        chk("rst_state", current_state, 0);
        chk("rst_humans", num_humans, 1);
        chk("rst_select", user_select, 0);
        chk("rst_active", active_seat, 0);
        chk("rst_win", win_mask, 0);
        chk("rst_push", push_mask, 0);
        chk("rst_over", game_over, 0);

        // human-count cycling: 1 -> 2 -> 0 -> 1, hold beats hit
        hold = 1; step(); hold = 0; chk("nh_a", num_humans, 2);
        hold = 1; step(); hold = 0; chk("nh_b", num_humans, 0);
        hold = 1; step(); hold = 0; chk("nh_c", num_humans, 1);
        hold = 1; hit = 1; step(); hold = 0; hit = 0;
        chk("hold_prio_state", current_state, 0);
        chk("hold_prio_nh", num_humans, 2);
        hold = 1; step(); hold = 0; chk("nh_d", num_humans, 0);
        hold = 1; step(); hold = 0; chk("nh_e", num_humans, 1);

        // game 1: full deal, human seat 1, AI seat 2 draws once, dealer draws
        hit = 1; step(); hit = 0;
        chk("start_deal", current_state, 1);
        run_deal();
        ai_hold = 1; step(); ai_hold = 0;
        chk("human_ignores_ai", current_state, 3);
        chk("human_ignores_ai_seat", active_seat, 1);
        hold = 1; step(); hold = 0;
        chk("seat1_hold", active_seat, 2);
        hold = 1; hit = 1; step(); hold = 0; hit = 0;
        chk("ai_ignores_btn_state", current_state, 3);
        chk("ai_ignores_btn_seat", active_seat, 2);
        ai_hit = 1; step(); ai_hit = 0;
        chk("ai_hit_draw", current_state, 2);
        chk("ai_hit_select", user_select, 2);
        cards_updated = 1; step(); cards_updated = 0;
        chk("ai_back_turn", current_state, 3);
        chk("ai_back_seat", active_seat, 2);
        chk("ai_back_select", user_select, 0);
        set_hands(20, 20, 18, 18, 10, 10);
        ai_hold = 1; step(); ai_hold = 0;
        chk("dealer_turn", current_state, 4);
        chk("dealer_active", active_seat, 3);
        step();
        chk("dealer_draw", current_state, 2);
        chk("dealer_select", user_select, 3);
        set_hands(20, 20, 18, 18, 18, 18);
        cards_updated = 1; step(); cards_updated = 0;
        chk("dealer_back", current_state, 4);
        step();
        chk("g1_result", current_state, 5);
        chk("g1_win", win_mask, 2'b01);
        chk("g1_push", push_mask, 2'b10);
        chk("g1_over", game_over, 1);
        chk("g1_active", active_seat, 0);
        hit = 1; step(); hit = 0;
        chk("g1_select", current_state, 0);
        chk("g1_clr_win", win_mask, 0);
        chk("g1_clr_push", push_mask, 0);
        chk("g1_clr_over", game_over, 0);
        chk("g1_keep_nh", num_humans, 1);

        // game 2: both players bust, dealer 12 never draws
        set_hands(24, 24, 24, 24, 12, 12);
        hit = 1; step(); hit = 0;
        run_deal();
        step(); chk("bust_adv1", active_seat, 2);
        step(); chk("bust_dealer", current_state, 4);
        step();
        chk("bust_result", current_state, 5);
        chk("bust_win", win_mask, 0);
        chk("bust_push", push_mask, 0);
        hold = 1; step(); hold = 0;
        chk("bust_select", current_state, 0);
        chk("bust_keep_nh", num_humans, 1);

        // game 3: dealer bust, player 2 scored on its low total
        set_hands(20, 20, 27, 17, 25, 25);
        hit = 1; step(); hit = 0;
        run_deal();
        hold = 1; step(); hold = 0;
        chk("g3_seat2", active_seat, 2);
        ai_hold = 1; step(); ai_hold = 0;
        chk("g3_dealer", current_state, 4);
        step();
        chk("g3_result", current_state, 5);
        chk("g3_win", win_mask, 2'b11);
        chk("g3_push", push_mask, 2'b00);
        hit = 1; step(); hit = 0;

        // game 4: seat 1 at 21 auto-advances, dealer soft 17
        set_hands(21, 21, 27, 17, 17, 7);
        hit = 1; step(); hit = 0;
        run_deal();
        step(); chk("g4_auto21", active_seat, 2);
        ai_hold = 1; step(); ai_hold = 0;
        chk("g4_dealer", current_state, 4);
        step();
`ifdef BLACKJACK_HIT_SOFT17_EN
        chk("soft17_draw", current_state, 2);
        chk("soft17_select", user_select, 3);
        set_hands(21, 21, 27, 17, 20, 20);
        cards_updated = 1; step(); cards_updated = 0;
        step();
        chk("soft17_result", current_state, 5);
        chk("soft17_win", win_mask, 2'b01);
        chk("soft17_push", push_mask, 2'b00);
`else
        chk("soft17_stand", current_state, 5);
        chk("soft17_win", win_mask, 2'b01);
        chk("soft17_push", push_mask, 2'b10);
`endif
        hit = 1; step(); hit = 0;
        chk("g4_select", current_state, 0);

        // reset in the middle of a draw
        hold = 1; step(); hold = 0;
        chk("g5_nh", num_humans, 2);
        hit = 1; step(); hit = 0;
        step();
        chk("g5_draw", current_state, 2);
        chk("g5_select", user_select, 1);
        rst = 1; step(); rst = 0;
        chk("mid_rst_state", current_state, 0);
        chk("mid_rst_select", user_select, 0);
        chk("mid_rst_nh", num_humans, 1);
        chk("mid_rst_active", active_seat, 0);
        hit = 1; step(); hit = 0;
        step();
        chk("post_rst_select", user_select, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
